// File: rtl/encoder_5x32_if.sv
// Match-vector bus for the 32-to-5 priority encoder.
// The master drives the match vector. The slave returns the encoded
// index and valid flag, both combinational and registered.
interface encoder_5x32_if;
  logic [31:0] in;
  logic [4:0]  out;
  logic        valid;
  logic [4:0]  out_q;
  logic        valid_q;

  modport master (
    output in,
    input  out, valid, out_q, valid_q
  );

  modport slave (
    input  in,
    output out, valid, out_q, valid_q
  );
endinterface

// File: rtl/encoder_5x32.sv
// 32-to-5 priority encoder. Bit 0 has the highest priority.
// out/valid are combinational from in. out_q/valid_q are one-cycle
// registered copies that are cleared by a synchronous active-high reset.
module encoder_5x32 (
  input  logic           clk,
  input  logic           reset,
  encoder_5x32_if.slave  bus
);

  logic [4:0] out_c;
  logic       valid_c;
  logic [4:0] out_r   = '0;
  logic       valid_r = 1'b0;

  // Lowest set index wins. Scanning downward lets lower bits overwrite
  // higher ones. An all-zero input leaves the default of 0.
  always_comb begin
    out_c = '0;
    for (int unsigned j = 32; j > 0; j--) begin
      if (bus.in[j-1]) out_c = 5'(j - 1);
    end
    valid_c = |bus.in;
  end

  // Register the encoded result. Reset takes priority over capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_r   <= '0;
      valid_r <= 1'b0;
    end else begin
      out_r   <= out_c;
      valid_r <= valid_c;
    end
  end

  assign bus.out     = out_c;
  assign bus.valid   = valid_c;
  assign bus.out_q   = out_r;
  assign bus.valid_q = valid_r;

endmodule

// File: tb/tb_encoder_5x32.sv
// Directed and random checks for encoder_5x32.
module tb_encoder_5x32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  encoder_5x32_if ifc ();

  encoder_5x32 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  // Reference model: scan upward from bit 0 and stop at the first set bit.
  function automatic logic [4:0] ref_idx(input logic [31:0] v);
    logic [4:0] r;
    logic found;
    r = 5'd0;
    found = 1'b0;
    for (int k = 0; k < 32; k++) begin
      if (!found && v[k]) begin
        r = 5'(k);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic test_reset();
    ifc.in = 32'h0000_0020;
    #1;
    checks++;
    if (ifc.out_q !== 5'd0 || ifc.valid_q !== 1'b0) begin
      errors++;
      $display("FAIL init_q: out_q=%0d valid_q=%b, required 0/0", ifc.out_q, ifc.valid_q);
    end
    @(posedge clk); #1;
    checks++;
    if (ifc.out_q !== 5'd0 || ifc.valid_q !== 1'b0) begin
      errors++;
      $display("FAIL reset_q: out_q=%0d valid_q=%b, required 0/0", ifc.out_q, ifc.valid_q);
    end
    checks++;
    if (ifc.out !== 5'd5 || ifc.valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_comb: out=%0d valid=%b, required 5/1", ifc.out, ifc.valid);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_onehot_sweep();
    for (int j = 0; j < 32; j++) begin
      @(negedge clk);
      ifc.in = 32'h1 << j;
      #1;
      checks++;
      if (ifc.out !== 5'(j) || ifc.valid !== 1'b1) begin
        errors++;
        $display("FAIL onehot_comb[%0d]: out=%0d valid=%b, required %0d/1", j, ifc.out, ifc.valid, j);
      end
      @(posedge clk); #1;
      checks++;
      if (ifc.out_q !== 5'(j) || ifc.valid_q !== 1'b1) begin
        errors++;
        $display("FAIL onehot_q[%0d]: out_q=%0d valid_q=%b, required %0d/1", j, ifc.out_q, ifc.valid_q, j);
      end
    end
  endtask

  task automatic test_zero();
    @(negedge clk);
    ifc.in = 32'h0;
    #1;
    checks++;
    if (ifc.out !== 5'd0 || ifc.valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_comb: out=%0d valid=%b, required 0/0", ifc.out, ifc.valid);
    end
    @(posedge clk); #1;
    checks++;
    if (ifc.out_q !== 5'd0 || ifc.valid_q !== 1'b0) begin
      errors++;
      $display("FAIL zero_q: out_q=%0d valid_q=%b, required 0/0", ifc.out_q, ifc.valid_q);
    end
  endtask

  task automatic test_priority();
    logic [31:0] vec [7];
    logic [4:0]  exp [7];
    vec[0] = 32'hFFFF_FFFF; exp[0] = 5'd0;
    vec[1] = 32'hF000_0000; exp[1] = 5'd28;
    vec[2] = 32'h8000_0100; exp[2] = 5'd8;
    vec[3] = 32'h0000_0001; exp[3] = 5'd0;
    vec[4] = 32'h8000_0000; exp[4] = 5'd31;
    vec[5] = 32'h8000_0002; exp[5] = 5'd1;
    vec[6] = 32'h0001_8000; exp[6] = 5'd15;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      ifc.in = vec[i];
      #1;
      checks++;
      if (ifc.out !== exp[i] || ifc.valid !== 1'b1) begin
        errors++;
        $display("FAIL priority_comb[%h]: out=%0d valid=%b, required %0d/1", vec[i], ifc.out, ifc.valid, exp[i]);
      end
      @(posedge clk); #1;
      checks++;
      if (ifc.out_q !== exp[i] || ifc.valid_q !== 1'b1) begin
        errors++;
        $display("FAIL priority_q[%h]: out_q=%0d valid_q=%b, required %0d/1", vec[i], ifc.out_q, ifc.valid_q, exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    ifc.in = 32'h0000_0400;
    @(posedge clk); #1;
    checks++;
    if (ifc.out_q !== 5'd10 || ifc.valid_q !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: out_q=%0d valid_q=%b, required 10/1", ifc.out_q, ifc.valid_q);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ifc.out_q !== 5'd0 || ifc.valid_q !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_q: out_q=%0d valid_q=%b, required 0/0", ifc.out_q, ifc.valid_q);
    end
    checks++;
    if (ifc.out !== 5'd10 || ifc.valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_comb: out=%0d valid=%b, required 10/1", ifc.out, ifc.valid);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ifc.out_q !== 5'd10 || ifc.valid_q !== 1'b1) begin
      errors++;
      $display("FAIL mid_post: out_q=%0d valid_q=%b, required 10/1", ifc.out_q, ifc.valid_q);
    end
  endtask

  task automatic test_random();
    logic [31:0] v;
    logic [4:0]  e;
    int          mode;
    for (int n = 0; n < 10000; n++) begin
      mode = $urandom_range(0, 4);
      if (mode == 0) begin
        v = $urandom;
      end else if (mode == 4) begin
        v = (n % 50 == 0) ? 32'h0 : $urandom;
      end else begin
        v = 32'h0;
        for (int b = 0; b < mode; b++) v[$urandom_range(0, 31)] = 1'b1;
      end
      e = ref_idx(v);
      @(negedge clk);
      ifc.in = v;
      #1;
      checks++;
      if (ifc.out !== e || ifc.valid !== (v != 32'h0)) begin
        errors++;
        $display("FAIL random_comb[%h]: out=%0d valid=%b, required %0d/%b", v, ifc.out, ifc.valid, e, v != 32'h0);
      end
      @(posedge clk); #1;
      checks++;
      if (ifc.out_q !== e || ifc.valid_q !== (v != 32'h0)) begin
        errors++;
        $display("FAIL random_q[%h]: out_q=%0d valid_q=%b, required %0d/%b", v, ifc.out_q, ifc.valid_q, e, v != 32'h0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_onehot_sweep();
    test_zero();
    test_priority();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/encoder_5x32.md
ENCODER_5X32 -- requirements
Module: encoder_5x32

Interface
REQ-001 The block SHALL have no parameters; widths are fixed at 32 input bits and 5 output bits.
REQ-002 Port clk, input, 1 bit: clock for the registered outputs.
REQ-003 Port reset, input, 1 bit: reset, synchronous, active-high; clock clk.
REQ-004 Port in, input, 32 bits: one-hot or multi-hot match vector; bit j corresponds to index j.
REQ-005 Port out, output, 5 bits: combinational index of the selected set bit of in.
REQ-006 Port valid, output, 1 bit: combinational; 1 when in has at least one set bit.
REQ-007 Port out_q, output, 5 bits: registered copy of out.
REQ-008 Port valid_q, output, 1 bit: registered copy of valid.

Function
REQ-009 out SHALL equal the index of the lowest-numbered set bit of in, so bit 0 has highest priority.
REQ-010 in with exactly one bit j set SHALL give out = j, for every j from 0 to 31.
REQ-011 Multiple set bits SHALL give out = the smallest set index; higher set bits are ignored.
REQ-012 in = 0 SHALL give out = 5'd0 and valid = 0.
- Consumers must qualify out with valid or with their own nonzero test of in.
REQ-013 out and valid SHALL be purely combinational, with zero-cycle latency from in.
- They SHALL NOT depend on clk or reset, so they are usable within the same cycle as in.
REQ-014 out and valid SHALL be free of X whenever in is free of X.
- No latches; every in value, including 0, SHALL map to a defined output.
REQ-015 On each rising edge of clk with reset = 0, out_q SHALL take out and valid_q SHALL take valid.
- Latency from in to out_q/valid_q is one cycle.
REQ-016 Boundary values of in:
- 32'h0000_0001 -> out 0.
- 32'h8000_0000 -> out 31.
- 32'hFFFF_FFFF -> out 0.
- 32'h8000_0002 -> out 1.
REQ-017 No handshake is defined; the block accepts a new in value every cycle.

Reset
REQ-018 While reset = 1 at a rising clk edge, out_q SHALL become 5'd0 and valid_q SHALL become 0 on that edge.
REQ-019 Reset SHALL NOT affect the combinational out and valid, which keep tracking in during reset.
REQ-020 Reset asserted mid-stream SHALL take priority over capture of in on that edge.
- The first edge after reset deasserts SHALL capture the current in.
REQ-021 Before the first clk edge, out_q and valid_q SHALL initialise to 0 for simulation.

Verification
REQ-022 One-hot sweep: for j = 0..31, drive in = 1<<j -> out = j and valid = 1 in the same cycle; out_q = j one cycle later.
REQ-023 Zero input: in = 0 -> out = 0, valid = 0; one cycle later out_q = 0 and valid_q = 0.
REQ-024 Priority:
- in = 32'hFFFF_FFFF -> out = 0.
- in = 32'hF000_0000 -> out = 28.
- in = 32'h8000_0100 -> out = 8.
- all with valid = 1.
REQ-025 Reset mid-operation: in = 32'h0000_0400 with out_q = 10, then assert reset for one edge.
- -> out_q = 0 and valid_q = 0, while out stays 10.
- After reset deasserts, the next edge -> out_q = 10 and valid_q = 1.
REQ-026 Random: 10,000 random in values, including sparse vectors with 1-3 bits set.
- -> out matches a reference lowest-set-bit model every cycle.
- -> out_q matches the previous cycle's model value.
